// File: rtl/delay_slot_arbiter.sv
// Round-robin arbiter sharing one external tick accumulator among
// several timing requesters; pulses done[i] when the count hits its limit.
module delay_slot_arbiter #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] limit,
  input  logic [WIDTH-1:0]       cnt_value,
  output logic                   cnt_plus,
  output logic                   cnt_rst,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [2:0]             grant_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [N_REQ-1:0] ONE =
    {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [2:0] LAST_RST = 3'(N_REQ-1);

  state_t           state;
  state_t           state_nx;
  logic [N_REQ-1:0] pending;
  logic [N_REQ-1:0] pending_nx;
  logic [N_REQ-1:0] clr_mask;
  logic [2:0]       last_grant;
  logic [2:0]       last_nx;
  logic [2:0]       gid_nx;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] lim_nx;
  logic [2:0]       sel_idx;
  logic [WIDTH-1:0] sel_lim;
  logic             hit;

  // First set bit searching upward from last_grant+1, wrapping at N_REQ.
  function automatic logic [2:0] rr_pick(
    input logic [N_REQ-1:0] p,
    input logic [2:0]       last
  );
    logic [2:0] pick;
    logic       found;
    int         c;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      c = (int'(last) + k) % N_REQ;
      if (!found && p[c]) begin
        found = 1'b1;
        pick  = 3'(c);
      end
    end
    return pick;
  endfunction

  assign sel_idx = rr_pick(pending, last_grant);
  assign sel_lim = limit[int'(sel_idx)*WIDTH +: WIDTH];
  assign hit     = (cnt_value == lim_q);

  always_comb begin
    state_nx = state;
    last_nx  = last_grant;
    gid_nx   = grant_id;
    lim_nx   = lim_q;
    clr_mask = '0;
    cnt_plus = 1'b0;
    cnt_rst  = 1'b0;
    done     = '0;
    busy     = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (pending != '0) begin
          gid_nx   = sel_idx;
          lim_nx   = sel_lim;
          clr_mask = ONE << sel_idx;
          state_nx = CLEAR;
        end
      end
      CLEAR: begin
        cnt_rst  = 1'b1;
        state_nx = COUNT;
      end
      COUNT: begin
        cnt_plus = !hit;
        if (hit) state_nx = DONE;
      end
      DONE: begin
        done     = ONE << grant_id;
        cnt_rst  = 1'b1;
        last_nx  = grant_id;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // A new request on the granted bit in the same cycle keeps it pending.
  assign pending_nx = (pending & ~clr_mask) | req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= LAST_RST;
      grant_id   <= '0;
      lim_q      <= '0;
    end else begin
      state      <= state_nx;
      pending    <= pending_nx;
      last_grant <= last_nx;
      grant_id   <= gid_nx;
      lim_q      <= lim_nx;
    end
  end

endmodule

// File: tb/tb_delay_slot_arbiter.sv
// Scoreboard bench for delay_slot_arbiter: directed requests push
// expected done events; a negedge monitor pops and compares them.
module tb_delay_slot_arbiter;

  localparam int N = 3;
  localparam int W = 24;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] limit = '0;
  logic [W-1:0]   cnt_value;
  logic           cnt_plus;
  logic           cnt_rst;
  logic [N-1:0]   done;
  logic           busy;
  logic [2:0]     grant_id;

  delay_slot_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .limit     (limit),
    .cnt_value (cnt_value),
    .cnt_plus  (cnt_plus),
    .cnt_rst   (cnt_rst),
    .done      (done),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  always #5 clk = ~clk;

  // External accumulator; ff_en jumps from 2 to max-2 for the wide test.
  logic [W-1:0] acc = '0;
  bit           ff_en = 1'b0;
  always @(posedge clk) begin
    if (cnt_rst)
      acc <= '0;
    else if (cnt_plus)
      acc <= (ff_en && acc == 24'd2) ? 24'hFFFFFD : acc + 1'b1;
  end
  assign cnt_value = acc;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           id;
    int           at;
    int           plus;
    logic [W-1:0] val;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   checks = 0;
  int   failures = 0;
  int   plus_cnt = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input int id, input int at,
                      input int plus, input logic [W-1:0] val);
    exp_t e;
    e.id = id;
    e.at = at;
    e.plus = plus;
    e.val = val;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      plus_cnt = 0;
    end else begin
      if (cnt_plus) plus_cnt++;
      if (done != '0) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got %b at cycle %0d expected none",
                   done, cyc);
        end else begin
          me = sbq.pop_front();
          chk("done_vec", 64'(done), 64'(1 << me.id));
          chk("done_cycle", 64'(cyc), 64'(me.at));
          chk("plus_cycles", 64'(plus_cnt), 64'(me.plus));
          chk("acc_at_done", 64'(cnt_value), 64'(me.val));
          chk("grant_id", 64'(grant_id), 64'(me.id));
        end
        plus_cnt = 0;
      end
    end
  end

  task automatic set_lim(input int i, input logic [W-1:0] v);
    limit[i*W +: W] = v;
  endtask

  task automatic pulse(input logic [N-1:0] r, output int t);
    @(negedge clk);
    req = r;
    t = cyc;
    @(negedge clk);
    req = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_cnt_plus"}, 64'(cnt_plus), 64'd0);
    chk({tag, "_cnt_rst"}, 64'(cnt_rst), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_quiet("rst");
      chk("rst_grant_id", 64'(grant_id), 64'd0);
    end
    rst = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sbq.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL %s_timeout: got %0d pending expected 0",
               tag, sbq.size());
      sbq.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int t;
    int nb;
    bit seen;

    // Reset then single request, limit 5.
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk_quiet("init_rst");
    end
    rst = 1'b1;
    set_lim(0, 24'd5);
    pulse(3'b001, t);
    push(0, t + 9, 5, 24'd5);
    nb = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("busy_cycles", 64'(nb), 64'd8);
    wait_idle("single");

    // Zero limit.
    set_lim(1, 24'd0);
    pulse(3'b010, t);
    push(1, t + 4, 0, 24'd0);
    wait_idle("zero");

    // Round-robin from a fresh reset.
    do_reset();
    set_lim(0, 24'd2);
    set_lim(1, 24'd3);
    set_lim(2, 24'd4);
    pulse(3'b111, t);
    push(0, t + 6, 2, 24'd2);
    push(1, t + 13, 3, 24'd3);
    push(2, t + 21, 4, 24'd4);
    wait_idle("rr3");

    pulse(3'b101, t);
    push(0, t + 6, 2, 24'd2);
    push(2, t + 14, 4, 24'd4);
    wait_idle("rr2");

    // Re-arm during service with a limit change.
    set_lim(0, 24'd4);
    set_lim(1, 24'd2);
    pulse(3'b001, t);
    repeat (3) @(negedge clk);
    set_lim(0, 24'd10);
    req = 3'b011;
    @(negedge clk);
    req = '0;
    push(0, t + 8, 4, 24'd4);
    push(1, t + 14, 2, 24'd2);
    push(0, t + 28, 10, 24'd10);
    wait_idle("rearm");

    // Reset in the middle of COUNT.
    set_lim(0, 24'd5);
    pulse(3'b001, t);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy && cnt_value == 24'd3) seen = 1'b1;
      else @(negedge clk);
    end
    chk("mid_reach_3", 64'(seen), 64'd1);
    rst = 1'b0;
    req = 3'b010;
    @(negedge clk);
    req = '0;
    chk_quiet("mid_rst");
    rst = 1'b1;
    nb = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy) nb++;
    end
    chk("mid_no_pending", 64'(nb), 64'd0);
    pulse(3'b001, t);
    push(0, t + 9, 5, 24'd5);
    wait_idle("mid_fresh");

    // Maximum limit with a fast-forwarded accumulator.
    ff_en = 1'b1;
    set_lim(2, 24'hFFFFFF);
    pulse(3'b100, t);
    push(2, t + 9, 5, 24'hFFFFFF);
    wait_idle("maxw");
    ff_en = 1'b0;
    chk("maxw_acc_cleared", 64'(cnt_value), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
